icache: RTL and testbench

Direct-mapped instruction cache between the instruction fetcher and the memory controller's ICache port. Serves one 32-bit instruction per request: a hit returns the next cycle, a miss issues a one-word refill to the memory controller and returns the word once the refill completes. Lines are one word (4 bytes), matching the controller's 4-byte block transfer. A flush abandons any in-flight refill and keeps cached contents valid.

---
 rtl/icache_if.sv | 38 +++
 rtl/icache.sv | 138 +++++++++++++
 tb/tb_icache.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// Bus bundle between the instruction cache, the instruction fetcher and the
// memory controller's ICache port.
//
// Handshake rules (all sampled on the rising clock edge):
//   fetch side : fetch_en is a one-cycle request.  It may only be pulsed while
//                cache_ready is high.  inst_valid is a one-cycle response
//                pulse.  inst_data and inst_pc hold their value until the next
//                response.
//   refill side: mem_query_en is a level request with mem_head_addr stable.
//                It stays high until the controller answers with a one-cycle
//                mem_block_en carrying mem_block_data.  The request drops on
//                the edge that samples mem_block_en.
interface icache_if;
    logic        fetch_en;
    logic [31:0] fetch_pc;
    logic        cache_ready;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        mem_query_en;
    logic [31:0] mem_head_addr;
    logic        mem_block_en;
    logic [31:0] mem_block_data;

    // Cache side of the bundle.
    modport slave (
        input  fetch_en, fetch_pc, mem_block_en, mem_block_data,
        output cache_ready, inst_valid, inst_data, inst_pc,
               mem_query_en, mem_head_addr
    );

    // Fetcher / memory-controller side of the bundle.
    modport master (
        output fetch_en, fetch_pc, mem_block_en, mem_block_data,
        input  cache_ready, inst_valid, inst_data, inst_pc,
               mem_query_en, mem_head_addr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache with one-word lines.  A hit answers on the
// next edge; a miss raises a one-word refill request and answers on the edge
// that sees the refill data.  A flush abandons an in-flight refill but leaves
// every stored line valid.  rdy_in low freezes the whole block.
module icache #(
    parameter int INDEX_WIDTH = 6
) (
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     rdy_in,
    input  logic     flush_signal,
    icache_if.slave  bus,
    output logic     state_dbg
);
    localparam int TAG_WIDTH = 30 - INDEX_WIDTH;
    localparam int LINES     = 1 << INDEX_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t state, state_next;

    logic [31:0]          data_q [LINES];
    logic [TAG_WIDTH-1:0] tag_q  [LINES];
    logic [LINES-1:0]     valid_q;

    logic [31:0]            miss_addr;
    logic [INDEX_WIDTH-1:0] req_idx;
    logic [TAG_WIDTH-1:0]   req_tag;
    logic [INDEX_WIDTH-1:0] miss_idx;
    logic [TAG_WIDTH-1:0]   miss_tag;
    logic                   req_hit;

    // Strobes decided by the FSM for this cycle.
    logic do_hit;
    logic do_miss;
    logic do_fill;

    assign req_idx  = bus.fetch_pc[INDEX_WIDTH+1:2];
    assign req_tag  = bus.fetch_pc[31:INDEX_WIDTH+2];
    assign miss_idx = miss_addr[INDEX_WIDTH+1:2];
    assign miss_tag = miss_addr[31:INDEX_WIDTH+2];
    assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign bus.cache_ready = (state == IDLE);
    assign state_dbg       = state;

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle strobes; flush beats every other event and
    // nothing moves while rdy_in is low.
    always_comb begin
        state_next = state;
        do_hit     = 1'b0;
        do_miss    = 1'b0;
        do_fill    = 1'b0;
        if (rdy_in) begin
            if (flush_signal) begin
                state_next = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.fetch_en) begin
                            if (req_hit) begin
                                do_hit = 1'b1;
                            end else begin
                                do_miss    = 1'b1;
                                state_next = MISS;
                            end
                        end
                    end
                    MISS: begin
                        if (bus.mem_block_en) begin
                            do_fill    = 1'b1;
                            state_next = IDLE;
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    // Registered outputs towards fetcher and memory controller.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bus.inst_valid    <= 1'b0;
            bus.inst_data     <= 32'h0;
            bus.inst_pc       <= 32'h0;
            bus.mem_query_en  <= 1'b0;
            bus.mem_head_addr <= 32'h0;
            miss_addr         <= 32'h0;
        end else if (rdy_in) begin
            // The request is high exactly while the FSM waits in MISS, so it
            // drops on the same edge that accepts the refill or the flush.
            bus.mem_query_en <= (state_next == MISS);
            bus.inst_valid   <= do_hit | do_fill;
            if (do_hit) begin
                bus.inst_data <= data_q[req_idx];
                bus.inst_pc   <= {bus.fetch_pc[31:2], 2'b00};
            end
            if (do_miss) begin
                bus.mem_head_addr <= {bus.fetch_pc[31:2], 2'b00};
                miss_addr         <= {bus.fetch_pc[31:2], 2'b00};
            end
            if (do_fill) begin
                bus.inst_data <= bus.mem_block_data;
                bus.inst_pc   <= miss_addr;
            end
        end
    end

    // Valid bits are the only storage cleared by reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else if (do_fill) begin
            valid_q[miss_idx] <= 1'b1;
        end
    end

    // Line data and tag arrays; a refill overwrites the indexed line.
    always_ff @(posedge clk_in) begin
        if (do_fill) begin
            data_q[miss_idx] <= bus.mem_block_data;
            tag_q[miss_idx]  <= miss_tag;
        end
    end
endmodule

// File: tb/tb_icache.sv
// Bench for icache: table of fetch vectors, hand sequences for flush, stall
// and reset corners, then random fetches against a residency model.
module tb_icache;
    timeunit 1ns;
    timeprecision 1ps;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rdy_in = 1'b1;
    logic flush_signal = 1'b0;
    logic state_dbg;

    icache_if bus ();

    icache #(.INDEX_WIDTH(6)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .flush_signal (flush_signal),
        .bus          (bus),
        .state_dbg    (state_dbg)
    );

    // Clock / reset block
    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    // Scoreboard: expected responses in order, popped when a response is seen.
    logic [31:0] exp_q[$];

    // Reference model: which word address each line index currently holds.
    logic [29:0] resident [int];

    typedef struct {
        logic [31:0] pc;
        bit          hit;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [31:0] a;
        a = {addr[31:2], 2'b00};
        case (a)
            32'h0000_0000: return 32'h0000_0513;
            32'h0000_0004: return 32'h00A0_0093;
            32'h0000_0100: return 32'h0010_0093;
            32'h0000_0040: return 32'h0000_0013;
            32'h0000_0080: return 32'h0000_8067;
            32'h0000_00C0: return 32'h0040_0113;
            default:       return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        bus.fetch_en = 1'b0;
        bus.mem_block_en = 1'b0;
        flush_signal = 1'b0;
        rdy_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
        resident.delete();
    endtask

    // Driver: one fetch, serving a refill after lat cycles if the cache asks.
    task automatic do_fetch(input logic [31:0] pc, input bit exp_hit,
                            input logic [31:0] exp_data, input int lat, input string nm);
        logic [31:0] wpc;
        wpc = {pc[31:2], 2'b00};
        exp_q.push_back(exp_data);
        chk({nm, "_ready"}, {31'h0, bus.cache_ready}, 32'h1);
        bus.fetch_en = 1'b1;
        bus.fetch_pc = pc;
        step();
        bus.fetch_en = 1'b0;
        if (exp_hit) begin
            chk({nm, "_hit_valid"}, {31'h0, bus.inst_valid}, 32'h1);
            chk({nm, "_hit_query"}, {31'h0, bus.mem_query_en}, 32'h0);
            chk({nm, "_hit_pc"}, bus.inst_pc, wpc);
        end else begin
            chk({nm, "_miss_query"}, {31'h0, bus.mem_query_en}, 32'h1);
            chk({nm, "_miss_valid"}, {31'h0, bus.inst_valid}, 32'h0);
            chk({nm, "_miss_head"}, bus.mem_head_addr, wpc);
            chk({nm, "_miss_ready"}, {31'h0, bus.cache_ready}, 32'h0);
        end
        // Serve a refill whenever one is pending, so a wrong hit/miss decision
        // does not desynchronise the rest of the run.
        if (bus.mem_query_en) begin
            for (int i = 0; i < lat; i++) begin
                step();
                chk({nm, "_query_held"}, {31'h0, bus.mem_query_en}, 32'h1);
            end
            bus.mem_block_en = 1'b1;
            bus.mem_block_data = mem_word(wpc);
            step();
            bus.mem_block_en = 1'b0;
            bus.mem_block_data = $urandom;
            chk({nm, "_fill_valid"}, {31'h0, bus.inst_valid}, 32'h1);
            chk({nm, "_fill_query"}, {31'h0, bus.mem_query_en}, 32'h0);
            chk({nm, "_fill_pc"}, bus.inst_pc, wpc);
        end
        if (bus.inst_valid && exp_q.size() > 0) begin
            chk({nm, "_data"}, bus.inst_data, exp_q.pop_front());
        end else begin
            chk({nm, "_no_response"}, {31'h0, bus.inst_valid}, 32'h1);
            exp_q.delete();
        end
        step();
        chk({nm, "_pulse_end"}, {31'h0, bus.inst_valid}, 32'h0);
    endtask

    // Model-driven fetch: expectation comes from the residency map.
    task automatic model_fetch(input logic [31:0] pc, input int lat, input string nm);
        int  idx;
        bit  hit;
        idx = int'(pc[31:2] % 64);
        hit = resident.exists(idx) && (resident[idx] == pc[31:2]);
        do_fetch(pc, hit, mem_word(pc), lat, nm);
        resident[idx] = pc[31:2];
    endtask

    initial begin
        bus.fetch_en = 1'b0;
        bus.fetch_pc = 32'h0;
        bus.mem_block_en = 1'b0;
        bus.mem_block_data = 32'h0;

        vecs[0] = '{32'h0000_0000, 1'b0, 32'h0000_0513};
        vecs[1] = '{32'h0000_0000, 1'b1, 32'h0000_0513};
        vecs[2] = '{32'h0000_0004, 1'b0, 32'h00A0_0093};
        vecs[3] = '{32'h0000_0006, 1'b1, 32'h00A0_0093};
        vecs[4] = '{32'h0000_0100, 1'b0, 32'h0010_0093};
        vecs[5] = '{32'h0000_0000, 1'b0, 32'h0000_0513};
        vecs[6] = '{32'h0000_0100, 1'b0, 32'h0010_0093};
        vecs[7] = '{32'h0000_0000, 1'b0, 32'h0000_0513};
        vecs[8] = '{32'h0000_0000, 1'b1, 32'h0000_0513};
        vecs[9] = '{32'h0000_0004, 1'b1, 32'h00A0_0093};

        do_reset();
        chk("rst_valid", {31'h0, bus.inst_valid}, 32'h0);
        chk("rst_data", bus.inst_data, 32'h0);
        chk("rst_pc", bus.inst_pc, 32'h0);
        chk("rst_query", {31'h0, bus.mem_query_en}, 32'h0);
        chk("rst_head", bus.mem_head_addr, 32'h0);
        chk("rst_ready", {31'h0, bus.cache_ready}, 32'h1);

        // Table-driven vectors: cold miss, hits, conflict eviction.
        for (int i = 0; i < 10; i++) begin
            do_fetch(vecs[i].pc, vecs[i].hit, vecs[i].data, i % 4, $sformatf("vec%0d", i));
        end

        // Back-to-back hits at 0x0 and 0x4.
        bus.fetch_en = 1'b1;
        bus.fetch_pc = 32'h0;
        step();
        chk("b2b_v0", {31'h0, bus.inst_valid}, 32'h1);
        chk("b2b_d0", bus.inst_data, 32'h0000_0513);
        bus.fetch_pc = 32'h4;
        step();
        bus.fetch_en = 1'b0;
        chk("b2b_v1", {31'h0, bus.inst_valid}, 32'h1);
        chk("b2b_d1", bus.inst_data, 32'h00A0_0093);
        chk("b2b_p1", bus.inst_pc, 32'h4);
        step();
        chk("b2b_end", {31'h0, bus.inst_valid}, 32'h0);

        // Flush two cycles after a missing fetch.
        bus.fetch_en = 1'b1;
        bus.fetch_pc = 32'h40;
        step();
        bus.fetch_en = 1'b0;
        chk("fl_query", {31'h0, bus.mem_query_en}, 32'h1);
        step();
        flush_signal = 1'b1;
        step();
        flush_signal = 1'b0;
        chk("fl_query_drop", {31'h0, bus.mem_query_en}, 32'h0);
        chk("fl_no_valid", {31'h0, bus.inst_valid}, 32'h0);
        chk("fl_ready", {31'h0, bus.cache_ready}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_quiet", {31'h0, bus.inst_valid | bus.mem_query_en}, 32'h0);
        end
        do_fetch(32'h40, 1'b0, 32'h0000_0013, 1, "fl_refetch");

        // Flush in the same cycle as the refill completion.
        bus.fetch_en = 1'b1;
        bus.fetch_pc = 32'h80;
        step();
        bus.fetch_en = 1'b0;
        chk("flb_query", {31'h0, bus.mem_query_en}, 32'h1);
        step();
        bus.mem_block_en = 1'b1;
        bus.mem_block_data = mem_word(32'h80);
        flush_signal = 1'b1;
        step();
        bus.mem_block_en = 1'b0;
        flush_signal = 1'b0;
        chk("flb_no_valid", {31'h0, bus.inst_valid}, 32'h0);
        chk("flb_query_drop", {31'h0, bus.mem_query_en}, 32'h0);
        step();
        chk("flb_quiet", {31'h0, bus.inst_valid}, 32'h0);
        do_fetch(32'h80, 1'b0, 32'h0000_8067, 0, "flb_refetch");

        // rdy_in low for 5 cycles during MISS.
        bus.fetch_en = 1'b1;
        bus.fetch_pc = 32'hC0;
        step();
        bus.fetch_en = 1'b0;
        chk("stall_query", {31'h0, bus.mem_query_en}, 32'h1);
        rdy_in = 1'b0;
        bus.mem_block_en = 1'b1;
        bus.mem_block_data = 32'hBAD0_BAD0;
        flush_signal = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_q_frozen", {31'h0, bus.mem_query_en}, 32'h1);
            chk("stall_v_frozen", {31'h0, bus.inst_valid}, 32'h0);
            chk("stall_head", bus.mem_head_addr, 32'hC0);
        end
        bus.mem_block_en = 1'b0;
        flush_signal = 1'b0;
        rdy_in = 1'b1;
        step();
        chk("stall_resume_q", {31'h0, bus.mem_query_en}, 32'h1);
        bus.mem_block_en = 1'b1;
        bus.mem_block_data = mem_word(32'hC0);
        step();
        bus.mem_block_en = 1'b0;
        chk("stall_fill_v", {31'h0, bus.inst_valid}, 32'h1);
        chk("stall_fill_d", bus.inst_data, 32'h0040_0113);

        // rdy_in low for 5 cycles while a hit pulse is up.
        step();
        bus.fetch_en = 1'b1;
        bus.fetch_pc = 32'hC0;
        step();
        bus.fetch_en = 1'b0;
        chk("stallh_v", {31'h0, bus.inst_valid}, 32'h1);
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stallh_v_held", {31'h0, bus.inst_valid}, 32'h1);
            chk("stallh_d_held", bus.inst_data, 32'h0040_0113);
        end
        rdy_in = 1'b1;
        step();
        chk("stallh_end", {31'h0, bus.inst_valid}, 32'h0);

        // Reset mid-MISS drops the request without waiting for an edge.
        bus.fetch_en = 1'b1;
        bus.fetch_pc = 32'h200;
        step();
        bus.fetch_en = 1'b0;
        chk("rmid_query", {31'h0, bus.mem_query_en}, 32'h1);
        #2;
        rst_in = 1'b1;
        #1;
        chk("rmid_query_async", {31'h0, bus.mem_query_en}, 32'h0);
        chk("rmid_valid", {31'h0, bus.inst_valid}, 32'h0);
        chk("rmid_ready", {31'h0, bus.cache_ready}, 32'h1);
        step();
        rst_in = 1'b0;
        resident.delete();
        model_fetch(32'h0, 1, "rmid_inv0");
        model_fetch(32'h4, 2, "rmid_inv1");
        model_fetch(32'hC0, 0, "rmid_inv2");

        // Randomised fetches against the residency model.
        for (int i = 0; i < 200; i++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
            model_fetch(pc, $urandom_range(0, 3), $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog: the run is bounded even if a task misbehaves.
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
